// File: rtl/stq_pkg.sv
// rtl/stq_pkg.sv - store-queue sizing, pointer type and range helper
package stq_pkg;

  localparam int DEPTH      = 16;
  localparam int INDEX      = 4;
  localparam int WIDTH      = 8;
  localparam int MAX_ALLOC  = 2;
  localparam int MAX_COMMIT = 2;

  typedef logic [INDEX:0] stq_ptr_t;

  // True when RAM index idx falls inside the live window [lo, hi); a window
  // spanning DEPTH entries (full queue) covers every index.
  function automatic logic stq_in_range(stq_ptr_t lo, stq_ptr_t hi, logic [INDEX-1:0] idx);
    stq_ptr_t         span;
    logic [INDEX-1:0] off;
    span = hi - lo;
    off  = idx - lo[INDEX-1:0];
    return {1'b0, off} < span;
  endfunction

endpackage

// File: rtl/stq_ptr.sv
// rtl/stq_ptr.sv - wrap-bit queue pointer with add-n increment and synchronous load
module stq_ptr
  import stq_pkg::*;
#(
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc_i,
  input  logic             load_i,
  input  stq_ptr_t         load_val_i,
  output stq_ptr_t         ptr_o
);

  stq_ptr_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q + stq_ptr_t'(inc_i);
    if (load_i) ptr_d = load_val_i;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/stq_ctrl.sv
// rtl/stq_ctrl.sv - store-queue controller: allocate, execute, commit, drain, recover
module stq_ctrl
  import stq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       allocCnt_i,
  output logic             allocReady_o,
  output logic [INDEX-1:0] allocIdx0_o,
  output logic [INDEX-1:0] allocIdx1_o,
  input  logic             exeWe_i,
  input  logic [INDEX-1:0] exeIdx_i,
  input  logic [WIDTH-1:0] exeData_i,
  input  logic [1:0]       commitCnt_i,
  input  logic             recover_i,
  output logic             drainValid_o,
  output logic [WIDTH-1:0] drainData_o,
  input  logic             drainReady_i,
  output logic [INDEX-1:0] ramAddr0_o,
  input  logic [WIDTH-1:0] ramData0_i,
  output logic [INDEX-1:0] ramAddr0wr_o,
  output logic [WIDTH-1:0] ramData0wr_o,
  output logic             ramWe0_o,
  output logic [INDEX:0]   count_o,
  output logic             empty_o,
  output logic             full_o
);

  stq_ptr_t         head, commit, tail, tail_p1;
  stq_ptr_t         commit_avail, commit_next;
  logic [1:0]       alloc_n, alloc_inc, commit_req, commit_n;
  logic             alloc_go, exe_live, drain_fire;
  logic [DEPTH-1:0] exec_q, exec_d;

  assign count_o      = tail - head;
  assign empty_o      = (count_o == '0);
  assign full_o       = (count_o == stq_ptr_t'(DEPTH));
  assign allocReady_o = (count_o <= stq_ptr_t'(DEPTH - MAX_ALLOC));

  assign tail_p1      = tail + stq_ptr_t'(1);
  assign allocIdx0_o  = tail[INDEX-1:0];
  assign allocIdx1_o  = tail_p1[INDEX-1:0];

  // An encoding of 3 is illegal and behaves like no request; recovery wins over allocation.
  assign alloc_n   = (allocCnt_i == 2'd3) ? 2'd0 : allocCnt_i;
  assign alloc_go  = allocReady_o & (alloc_n != 2'd0) & ~recover_i;
  assign alloc_inc = alloc_go ? alloc_n : 2'd0;

  assign commit_avail = tail - commit;
  assign commit_req   = (commitCnt_i > 2'(MAX_COMMIT)) ? 2'(MAX_COMMIT) : commitCnt_i;
  assign commit_n     = (stq_ptr_t'(commit_req) > commit_avail) ? commit_avail[1:0] : commit_req;
  assign commit_next  = commit + stq_ptr_t'(commit_n);

  // Only live, uncommitted entries may be written by execute.
  assign exe_live     = stq_in_range(commit, tail, exeIdx_i);
  assign ramWe0_o     = exeWe_i & exe_live & ~recover_i & ~reset;
  assign ramAddr0wr_o = exeIdx_i;
  assign ramData0wr_o = exeData_i;

  assign ramAddr0_o   = head[INDEX-1:0];
  assign drainData_o  = ramData0_i;
  assign drainValid_o = (head != commit) & exec_q[head[INDEX-1:0]];
  assign drain_fire   = drainValid_o & drainReady_i;

  always_comb begin
    exec_d = exec_q;
    if (ramWe0_o) exec_d[exeIdx_i] = 1'b1;
    if (alloc_go) begin
      exec_d[tail[INDEX-1:0]] = 1'b0;
      if (alloc_n == 2'd2) exec_d[tail_p1[INDEX-1:0]] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) exec_q <= '0;
    else       exec_q <= exec_d;
  end

  stq_ptr #(.INC_W(2)) u_head (
    .clk        (clk),
    .reset      (reset),
    .inc_i      ({1'b0, drain_fire}),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (head)
  );

  stq_ptr #(.INC_W(2)) u_commit (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (commit_n),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (commit)
  );

  // Recovery snaps tail back to the post-commit pointer, discarding speculative stores.
  stq_ptr #(.INC_W(2)) u_tail (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (alloc_inc),
    .load_i     (recover_i),
    .load_val_i (commit_next),
    .ptr_o      (tail)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(alloc_n != 2'd0 && !allocReady_o))
        else $warning("stq_ctrl: allocation dropped, fewer than %0d free entries", MAX_ALLOC);
      assert (stq_ptr_t'(commitCnt_i) <= commit_avail)
        else $warning("stq_ctrl: commit count clipped to %0d", commit_n);
    end
  end

endmodule

// File: tb/tb_stq_ctrl.sv
// tb/tb_stq_ctrl.sv - scoreboard bench for stq_ctrl with a sequence-number reference model
module tb_stq_ctrl;
  import stq_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       allocCnt_i;
  logic             allocReady_o;
  logic [INDEX-1:0] allocIdx0_o, allocIdx1_o;
  logic             exeWe_i;
  logic [INDEX-1:0] exeIdx_i;
  logic [WIDTH-1:0] exeData_i;
  logic [1:0]       commitCnt_i;
  logic             recover_i;
  logic             drainValid_o;
  logic [WIDTH-1:0] drainData_o;
  logic             drainReady_i;
  logic [INDEX-1:0] ramAddr0_o;
  logic [WIDTH-1:0] ramData0_i;
  logic [INDEX-1:0] ramAddr0wr_o;
  logic [WIDTH-1:0] ramData0wr_o;
  logic             ramWe0_o;
  logic [INDEX:0]   count_o;
  logic             empty_o, full_o;

  stq_ctrl dut (
    .clk(clk), .reset(reset),
    .allocCnt_i(allocCnt_i), .allocReady_o(allocReady_o),
    .allocIdx0_o(allocIdx0_o), .allocIdx1_o(allocIdx1_o),
    .exeWe_i(exeWe_i), .exeIdx_i(exeIdx_i), .exeData_i(exeData_i),
    .commitCnt_i(commitCnt_i), .recover_i(recover_i),
    .drainValid_o(drainValid_o), .drainData_o(drainData_o), .drainReady_i(drainReady_i),
    .ramAddr0_o(ramAddr0_o), .ramData0_i(ramData0_i),
    .ramAddr0wr_o(ramAddr0wr_o), .ramData0wr_o(ramData0wr_o), .ramWe0_o(ramWe0_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  // Store-queue RAM stand-in: combinational read, posedge write.
  logic [WIDTH-1:0] ram [DEPTH];
  assign ramData0_i = ram[ramAddr0_o];
  always @(posedge clk) if (ramWe0_o === 1'b1) ram[ramAddr0wr_o] <= ramData0wr_o;

  // Reference model: absolute sequence numbers that never wrap.
  int               m_head, m_commit, m_tail;
  bit               m_exec [int];
  logic [WIDTH-1:0] m_data [int];
  logic [WIDTH-1:0] sb_q [$];
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && drainValid_o === 1'b1 && drainReady_i === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain_unexpected: got data %0h expected no drain", drainData_o);
      end else begin
        chk("drain_data", drainData_o, sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; allocCnt_i = 2'd0; exeWe_i = 1'b1; exeIdx_i = '0; exeData_i = '0;
    commitCnt_i = 2'd0; recover_i = 1'b0; drainReady_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_ready", allocReady_o, 1);
    chk("rst_alloc_idx0", allocIdx0_o, 0);
    chk("rst_alloc_idx1", allocIdx1_o, 1);
    chk("rst_drain_valid", drainValid_o, 0);
    chk("rst_ram_we0", ramWe0_o, 0);
    chk("rst_ram_addr0", ramAddr0_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    reset = 1'b0; exeWe_i = 1'b0; drainReady_i = 1'b0;
    m_head = 0; m_commit = 0; m_tail = 0;
    m_exec.delete(); m_data.delete(); sb_q.delete();
  endtask

  // One clock: drive, check against the model, advance the model, take the edge.
  task automatic cyc(input int a, input bit we, input int eidx, input logic [WIDTH-1:0] ed,
                     input int c, input bit rec, input bit rdy);
    int cnt, an, cn, eabs;
    bit ev, ew;
    allocCnt_i = a[1:0]; exeWe_i = we; exeIdx_i = eidx[INDEX-1:0]; exeData_i = ed;
    commitCnt_i = c[1:0]; recover_i = rec; drainReady_i = rdy;
    #2;
    cnt = m_tail - m_head;
    chk("count", count_o, cnt);
    chk("empty", empty_o, cnt == 0);
    chk("full", full_o, cnt == DEPTH);
    chk("alloc_ready", allocReady_o, cnt <= DEPTH - 2);
    chk("alloc_idx0", allocIdx0_o, m_tail % DEPTH);
    chk("alloc_idx1", allocIdx1_o, (m_tail + 1) % DEPTH);
    chk("ram_addr0", ramAddr0_o, m_head % DEPTH);
    ev = (m_head < m_commit) && m_exec.exists(m_head) && m_exec[m_head];
    chk("drain_valid", drainValid_o, ev);
    eabs = -1;
    for (int j = m_commit; j < m_tail; j++) if (j % DEPTH == eidx) eabs = j;
    ew = we && (eabs >= 0) && !rec;
    chk("ram_we0", ramWe0_o, ew);
    if (ew) chk("ram_wr_addr", ramAddr0wr_o, eidx);
    cn = (c > m_tail - m_commit) ? (m_tail - m_commit) : c;
    if (ew) begin m_exec[eabs] = 1'b1; m_data[eabs] = ed; end
    for (int k = 0; k < cn; k++) sb_q.push_back(m_data[m_commit + k]);
    m_commit += cn;
    an = (a == 3) ? 0 : a;
    if (an > 0 && cnt <= DEPTH - 2 && !rec) begin
      for (int k = 0; k < an; k++) m_exec[m_tail + k] = 1'b0;
      m_tail += an;
    end
    if (ev && rdy) m_head++;
    if (rec) m_tail = m_commit;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int allocated, a, c, run, eidx, budget;
    bit we;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;

    // Fill with pairs until full; the extra request is dropped.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(2, 0, 0, 8'h00, 0, 0, 0);
    chk("full_count_held", count_o, 16);
    chk("full_flag", full_o, 1);

    // Single store, drain held off for three cycles.
    do_reset();
    cyc(1, 0, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 0, 8'hA5, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", drainValid_o, 1);
      chk("hold_data", drainData_o, 8'hA5);
      cyc(0, 0, 0, 8'h00, 0, 0, 0);
    end
    cyc(0, 0, 0, 8'h00, 0, 0, 1);
    chk("popped_empty", empty_o, 1);

    // Recover squashes the two uncommitted entries.
    do_reset();
    cyc(2, 0, 0, 8'h00, 0, 0, 0);
    cyc(2, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, i, 8'(8'h10 + i), 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 2, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 1, 0);
    chk("recover_count", count_o, 2);
    chk("recover_tail", allocIdx0_o, 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 0, 1);
    cyc(1, 0, 0, 8'h00, 0, 0, 0);
    chk("post_recover_count", count_o, 1);

    // Out-of-range execute and the illegal alloc encoding.
    do_reset();
    cyc(0, 1, 5, 8'h3C, 0, 0, 0);
    cyc(3, 0, 0, 8'h00, 0, 0, 0);
    chk("illegal_alloc_count", count_o, 0);

    // Random round trips across both pointer wraps.
    do_reset();
    allocated = 0;
    budget = 0;
    while (m_head < 40 && budget < 3000) begin
      a = $urandom_range(0, 2);
      if (a > 40 - allocated) a = 40 - allocated;
      if (a > 0 && (m_tail - m_head) <= DEPTH - 2) allocated += a;
      we = 1'b0; eidx = 0;
      if ($urandom_range(0, 3) != 0)
        for (int j = m_commit; j < m_tail; j++)
          if (!we && !m_exec[j]) begin we = 1'b1; eidx = j % DEPTH; end
      run = 0;
      for (int j = m_commit; j < m_tail && run < MAX_COMMIT; j++) begin
        if (!m_exec[j]) break;
        run++;
      end
      c = $urandom_range(0, run);
      cyc(a, we, eidx, 8'($urandom), c, 0, 1'($urandom_range(0, 1)));
      budget++;
    end
    if (m_head < 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL wrap_timeout: got %0d drained expected 40", m_head);
    end
    chk("wrap_drain_count", count_o, m_tail - m_head);

    // Alloc 2, commit 1 and drain 1 together from count 5.
    do_reset();
    cyc(2, 0, 0, 8'h00, 0, 0, 0);
    cyc(2, 0, 0, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 0, 8'hAA, 0, 0, 0);
    cyc(0, 1, 1, 8'hBB, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 1, 0, 0);
    chk("pre_same_count", count_o, 5);
    cyc(2, 0, 0, 8'h00, 1, 0, 1);
    chk("same_cycle_count", count_o, 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
